// File: rtl/core_sequencer_pkg.sv
// Shared core-state encodings and helpers for the sequencer and the
// per-lane register, ALU, LSU and PC units.
package core_sequencer_pkg;

    localparam logic [3:0] CORE_IDLE    = 4'b0000;
    localparam logic [3:0] CORE_FETCH   = 4'b0001;
    localparam logic [3:0] CORE_DECODE  = 4'b0010;
    localparam logic [3:0] CORE_ISSUE   = 4'b0011;
    localparam logic [3:0] CORE_REQUEST = 4'b0100;
    localparam logic [3:0] CORE_WAIT    = 4'b0101;
    localparam logic [3:0] CORE_EXECUTE = 4'b0110;
    localparam logic [3:0] CORE_UPDATE  = 4'b0111;
    localparam logic [3:0] CORE_DONE    = 4'b1000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer control bundle: instruction/LSU status in, core state and PC out.
interface core_sequencer_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PROGRAM_ADDR_BITS = 8
);
    logic                         start;
    logic                         fetch_done;
    logic                         decoded_mem_read_enable;
    logic                         decoded_mem_write_enable;
    logic                         decoded_ret;
    logic [THREADS_PER_BLOCK-1:0] thread_enable;
    logic [THREADS_PER_BLOCK-1:0] lsu_done;
    logic [PROGRAM_ADDR_BITS-1:0] next_pc;

    logic [3:0]                   core_state;
    logic [PROGRAM_ADDR_BITS-1:0] current_pc;
    logic                         done;
    logic                         error;
    logic [15:0]                  retired_count;

    modport master (
        output start, fetch_done, decoded_mem_read_enable, decoded_mem_write_enable,
               decoded_ret, thread_enable, lsu_done, next_pc,
        input  core_state, current_pc, done, error, retired_count
    );

    modport slave (
        input  start, fetch_done, decoded_mem_read_enable, decoded_mem_write_enable,
               decoded_ret, thread_enable, lsu_done, next_pc,
        output core_state, current_pc, done, error, retired_count
    );
endinterface

// File: rtl/core_sequencer.sv
// Per-core instruction sequencer: steps one instruction at a time through
// fetch/decode/issue/memory/execute/update, with a watchdog on memory waits.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | waiting for fetcher to hold a valid instruction
// DECODE  | decoder resolves control signals
// ISSUE   | register files capture rs/rt
// REQUEST | LSUs launch memory requests
// WAIT    | waiting for all active lanes' LSUs (watchdog running)
// EXECUTE | ALUs compute, lane 0 produces next_pc
// UPDATE  | write-back, retire, advance PC
// DONE    | kernel finished or timed out; sticky until reset
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int          THREADS_PER_BLOCK   = 4,
    parameter int          PROGRAM_ADDR_BITS   = 8,
    parameter int          MAX_WAIT            = 255,
    parameter logic [15:0] RETIRED_RESET_VALUE = 16'h0000
) (
    input logic             clk,
    input logic             reset,
    core_sequencer_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [3:0]                   state_q;
    logic [PROGRAM_ADDR_BITS-1:0] pc_q;
    logic                         done_q;
    logic                         error_q;
    logic [15:0]                  retired_q;
    logic [WAIT_W-1:0]            wait_cnt_q;

    logic [THREADS_PER_BLOCK-1:0] lane_ok;
    logic                         mem_op;
    logic                         lanes_done;
    logic                         wait_limit;

    // Disabled lanes count as finished so a partial block never stalls.
    assign lane_ok    = bus.lsu_done | ~bus.thread_enable;
    assign lanes_done = &lane_ok;
    assign mem_op     = bus.decoded_mem_read_enable | bus.decoded_mem_write_enable;
    assign wait_limit = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CORE_IDLE;
            pc_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            retired_q  <= RETIRED_RESET_VALUE;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                CORE_IDLE:    if (bus.start) state_q <= CORE_FETCH;
                CORE_FETCH:   if (bus.fetch_done) state_q <= CORE_DECODE;
                CORE_DECODE:  state_q <= CORE_ISSUE;
                CORE_ISSUE:   state_q <= CORE_REQUEST;
                CORE_REQUEST: begin
                    state_q    <= CORE_WAIT;
                    wait_cnt_q <= '0;
                end
                CORE_WAIT: begin
                    if (!mem_op || lanes_done) begin
                        state_q <= CORE_EXECUTE;
                    end else if (wait_limit) begin
                        state_q <= CORE_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                CORE_EXECUTE: state_q <= CORE_UPDATE;
                CORE_UPDATE: begin
                    retired_q <= sat_inc16(retired_q);
                    if (bus.decoded_ret) begin
                        state_q <= CORE_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q    <= bus.next_pc;
                        state_q <= CORE_FETCH;
                    end
                end
                CORE_DONE:    state_q <= CORE_DONE;
                default:      state_q <= CORE_IDLE;
            endcase
        end
    end

    assign bus.core_state    = state_q;
    assign bus.current_pc    = pc_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench: expected state transitions are queued by the stimulus and
// checked by per-DUT monitors each time core_state changes.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    typedef struct {
        logic [3:0]  st;
        logic [7:0]  pc;
        logic        dn;
        logic        er;
        logic [15:0] rc;
        int          dwell;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    always #5 clk = ~clk;

    core_sequencer_if #(.THREADS_PER_BLOCK(4), .PROGRAM_ADDR_BITS(8)) ifa ();
    core_sequencer_if #(.THREADS_PER_BLOCK(4), .PROGRAM_ADDR_BITS(8)) ifb ();

    core_sequencer #(.THREADS_PER_BLOCK(4), .PROGRAM_ADDR_BITS(8), .MAX_WAIT(4)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa.slave));

    core_sequencer #(.THREADS_PER_BLOCK(4), .PROGRAM_ADDR_BITS(8), .MAX_WAIT(255),
                     .RETIRED_RESET_VALUE(16'hFFFE)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb.slave));

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input bit b, input logic [3:0] st, input logic [7:0] pc,
                        input logic dn, input logic er, input logic [15:0] rc, input int dw);
        exp_t e;
        e.st = st; e.pc = pc; e.dn = dn; e.er = er; e.rc = rc; e.dwell = dw;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
    endtask

    // DECODE through UPDATE of one instruction; dec_dw is the FETCH dwell, wait_dw the WAIT dwell.
    task automatic push_body(input bit b, input logic [7:0] pc, input logic [15:0] rc,
                             input int dec_dw, input int wait_dw);
        push(b, CORE_DECODE,  pc, 1'b0, 1'b0, rc, dec_dw);
        push(b, CORE_ISSUE,   pc, 1'b0, 1'b0, rc, 1);
        push(b, CORE_REQUEST, pc, 1'b0, 1'b0, rc, 1);
        push(b, CORE_WAIT,    pc, 1'b0, 1'b0, rc, 1);
        push(b, CORE_EXECUTE, pc, 1'b0, 1'b0, rc, wait_dw);
        push(b, CORE_UPDATE,  pc, 1'b0, 1'b0, rc, 1);
    endtask

    task automatic compare_rec(input string tag, input exp_t e, input logic [3:0] st,
                               input logic [7:0] pc, input logic dn, input logic er,
                               input logic [15:0] rc, input int dw);
        chk({tag, "_state"},   st, e.st);
        chk({tag, "_pc"},      pc, e.pc);
        chk({tag, "_done"},    dn, e.dn);
        chk({tag, "_error"},   er, e.er);
        chk({tag, "_retired"}, rc, e.rc);
        if (e.dwell >= 0) chk({tag, "_dwell"}, dw, e.dwell);
    endtask

    task automatic wait_st(input bit b, input logic [3:0] s, input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((b ? ifb.core_state : ifa.core_state) == s) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout actual=%0h required=%0h", name,
                 b ? ifb.core_state : ifa.core_state, s);
    endtask

    logic [3:0] prev_a = 4'hF;
    logic [3:0] prev_b = 4'hF;
    int         dwell_a = 0;
    int         dwell_b = 0;

    always @(negedge clk) begin
        if (ifa.core_state !== prev_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_transition actual=%0h required=no_change", ifa.core_state);
            end else begin
                compare_rec("a", q_a.pop_front(), ifa.core_state, ifa.current_pc, ifa.done,
                            ifa.error, ifa.retired_count, dwell_a);
            end
            dwell_a = 1;
        end else begin
            dwell_a = dwell_a + 1;
        end
        prev_a = ifa.core_state;
    end

    always @(negedge clk) begin
        if (ifb.core_state !== prev_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_transition actual=%0h required=no_change", ifb.core_state);
            end else begin
                compare_rec("b", q_b.pop_front(), ifb.core_state, ifb.current_pc, ifb.done,
                            ifb.error, ifb.retired_count, dwell_b);
            end
            dwell_b = 1;
        end else begin
            dwell_b = dwell_b + 1;
        end
        prev_b = ifb.core_state;
    end

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        ifa.start = 1'b0; ifa.fetch_done = 1'b1; ifa.decoded_mem_read_enable = 1'b0;
        ifa.decoded_mem_write_enable = 1'b0; ifa.decoded_ret = 1'b0;
        ifa.thread_enable = 4'b1111; ifa.lsu_done = 4'b0000; ifa.next_pc = 8'h10;
        ifb.start = 1'b0; ifb.fetch_done = 1'b1; ifb.decoded_mem_read_enable = 1'b1;
        ifb.decoded_mem_write_enable = 1'b0; ifb.decoded_ret = 1'b0;
        ifb.thread_enable = 4'b0000; ifb.lsu_done = 4'b0000; ifb.next_pc = 8'hFF;

        // plain instruction: 1,2,3,4,5,6,7,1 with one-cycle WAIT
        push(0, CORE_IDLE,  8'h00, 1'b0, 1'b0, 16'd0, -1);
        push(0, CORE_FETCH, 8'h00, 1'b0, 1'b0, 16'd0, -1);
        push_body(0, 8'h00, 16'd0, 1, 1);
        push(0, CORE_FETCH, 8'h10, 1'b0, 1'b0, 16'd1, 1);
        push(1, CORE_IDLE,  8'h00, 1'b0, 1'b0, 16'hFFFE, -1);
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_st(0, CORE_UPDATE, "t1_update");
        ifa.fetch_done = 1'b0;
        @(negedge clk);

        // LDR on lanes 0..2, lane 3 disabled and never completes
        push_body(0, 8'h10, 16'd1, -1, 3);
        push(0, CORE_FETCH, 8'h2A, 1'b0, 1'b0, 16'd2, 1);
        ifa.decoded_mem_read_enable = 1'b1;
        ifa.thread_enable = 4'b0111;
        ifa.next_pc = 8'h2A;
        ifa.fetch_done = 1'b1;
        wait_st(0, CORE_WAIT, "t2_wait");
        ifa.lsu_done = 4'b0001;
        @(negedge clk);
        ifa.lsu_done = 4'b0011;
        @(negedge clk);
        ifa.lsu_done = 4'b0111;
        ifa.fetch_done = 1'b0;
        wait_st(0, CORE_UPDATE, "t2_update");
        ifa.decoded_mem_read_enable = 1'b0;
        ifa.lsu_done = 4'b0000;
        @(negedge clk);

        // reset mid-WAIT with current_pc=2A
        push(0, CORE_DECODE,  8'h2A, 1'b0, 1'b0, 16'd2, -1);
        push(0, CORE_ISSUE,   8'h2A, 1'b0, 1'b0, 16'd2, 1);
        push(0, CORE_REQUEST, 8'h2A, 1'b0, 1'b0, 16'd2, 1);
        push(0, CORE_WAIT,    8'h2A, 1'b0, 1'b0, 16'd2, 1);
        push(0, CORE_IDLE,    8'h00, 1'b0, 1'b0, 16'd0, 1);
        ifa.decoded_mem_write_enable = 1'b1;
        ifa.thread_enable = 4'b1111;
        ifa.fetch_done = 1'b1;
        wait_st(0, CORE_WAIT, "t3_wait");
        reset_a = 1'b1;
        ifa.fetch_done = 1'b0;
        ifa.decoded_mem_write_enable = 1'b0;
        @(negedge clk);

        // STR that never completes: watchdog after 4 WAIT cycles
        push(0, CORE_FETCH,   8'h00, 1'b0, 1'b0, 16'd0, -1);
        push(0, CORE_DECODE,  8'h00, 1'b0, 1'b0, 16'd0, 1);
        push(0, CORE_ISSUE,   8'h00, 1'b0, 1'b0, 16'd0, 1);
        push(0, CORE_REQUEST, 8'h00, 1'b0, 1'b0, 16'd0, 1);
        push(0, CORE_WAIT,    8'h00, 1'b0, 1'b0, 16'd0, 1);
        push(0, CORE_DONE,    8'h00, 1'b1, 1'b1, 16'd0, 4);
        reset_a = 1'b0;
        ifa.start = 1'b1;
        ifa.fetch_done = 1'b1;
        ifa.decoded_mem_write_enable = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_st(0, CORE_DONE, "t4_done");
        ifa.fetch_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ifa.start = ~ifa.start;
            @(negedge clk);
        end
        ifa.start = 1'b0;

        // RET: DONE with current_pc kept, start ignored afterwards
        push(0, CORE_IDLE, 8'h00, 1'b0, 1'b0, 16'd0, -1);
        reset_a = 1'b1;
        ifa.decoded_mem_write_enable = 1'b0;
        @(negedge clk);
        push(0, CORE_FETCH, 8'h00, 1'b0, 1'b0, 16'd0, -1);
        push_body(0, 8'h00, 16'd0, 1, 1);
        push(0, CORE_DONE, 8'h00, 1'b1, 1'b0, 16'd1, 1);
        reset_a = 1'b0;
        ifa.start = 1'b1;
        ifa.fetch_done = 1'b1;
        ifa.decoded_ret = 1'b1;
        ifa.next_pc = 8'h55;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_st(0, CORE_DONE, "t5_done");
        ifa.fetch_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ifa.start = ~ifa.start;
            @(negedge clk);
        end
        ifa.start = 1'b0;

        // PC FF then 00, retired_count saturating, empty mask passes WAIT
        push(1, CORE_FETCH, 8'h00, 1'b0, 1'b0, 16'hFFFE, -1);
        push_body(1, 8'h00, 16'hFFFE, 1, 1);
        push(1, CORE_FETCH, 8'hFF, 1'b0, 1'b0, 16'hFFFF, 1);
        reset_b = 1'b0;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        wait_st(1, CORE_UPDATE, "t6_update1");
        @(negedge clk);
        push_body(1, 8'hFF, 16'hFFFF, 1, 1);
        push(1, CORE_FETCH, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1);
        ifb.next_pc = 8'h00;
        ifb.decoded_mem_read_enable = 1'b0;
        wait_st(1, CORE_UPDATE, "t6_update2");
        @(negedge clk);
        push_body(1, 8'h00, 16'hFFFF, 1, 1);
        push(1, CORE_DONE, 8'h00, 1'b1, 1'b0, 16'hFFFF, 1);
        ifb.decoded_ret = 1'b1;
        wait_st(1, CORE_DONE, "t6_done");
        ifb.fetch_done = 1'b0;
        repeat (3) @(negedge clk);

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4, number of thread lanes tracked.
REQ-002 Parameter PROGRAM_ADDR_BITS, default 8, width of current_pc and next_pc.
REQ-003 Parameter MAX_WAIT, default 255, WAIT-state cycle limit before error.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, level; begins kernel execution from IDLE.
REQ-007 Port fetch_done, input, 1, level; fetcher holds a valid instruction.
REQ-008 Port decoded_mem_read_enable, input, 1, current instruction is LDR.
REQ-009 Port decoded_mem_write_enable, input, 1, current instruction is STR.
REQ-010 Port decoded_ret, input, 1, current instruction is RET.
REQ-011 Port thread_enable, input, THREADS_PER_BLOCK, active-lane mask for the current block.
REQ-012 Port lsu_done, input, THREADS_PER_BLOCK, per-lane level; that lane's memory access has completed.
REQ-013 Port next_pc, input, PROGRAM_ADDR_BITS, PC computed by lane 0 during EXECUTE.
REQ-014 Port core_state, output, 4, current sequencer state, consumed by the register files, ALUs, LSUs and PC units.
REQ-015 Port current_pc, output, PROGRAM_ADDR_BITS, address of the instruction being processed.
REQ-016 Port done, output, 1, kernel finished.
REQ-017 Port error, output, 1, WAIT timeout occurred.
REQ-018 Port retired_count, output, 16, number of instructions retired.

Function
REQ-019 State encodings SHALL be: IDLE 0000, FETCH 0001, DECODE 0010, ISSUE 0011, REQUEST 0100, WAIT 0101, EXECUTE 0110, UPDATE 0111, DONE 1000.
REQ-020 IDLE SHALL move to FETCH on the first edge with start=1, and SHALL otherwise hold.
REQ-021 FETCH SHALL hold until fetch_done=1, then move to DECODE.
REQ-022 DECODE, ISSUE, REQUEST and EXECUTE SHALL each last exactly one cycle.
REQ-023 Those four states SHALL advance in the order DECODE, ISSUE, REQUEST, WAIT (after REQUEST), EXECUTE (after WAIT), UPDATE (after EXECUTE).
REQ-024 ISSUE SHALL be the single cycle in which downstream register files capture rs/rt.
REQ-025 WAIT with neither mem enable asserted SHALL last one cycle.
REQ-026 WAIT with a mem enable asserted SHALL hold until (lsu_done | ~thread_enable) is all ones; an all-zero thread_enable SHALL pass after one cycle.
REQ-027 A WAIT counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 If the WAIT counter reaches MAX_WAIT without completion, the sequencer SHALL enter DONE with error=1 and done=1 on the same edge.
REQ-029 UPDATE SHALL increment retired_count, saturating at 16'hFFFF.
REQ-030 UPDATE with decoded_ret=1 SHALL enter DONE with done=1 and leave current_pc unchanged.
REQ-031 UPDATE otherwise SHALL load current_pc with next_pc (no local arithmetic; wrap is the PC unit's concern) and return to FETCH.
REQ-032 DONE SHALL be sticky until reset; start SHALL be ignored in every state except IDLE.
REQ-033 All outputs SHALL be registered; core_state SHALL equal the registered state.

Reset
REQ-034 On reset the sequencer SHALL set core_state=IDLE, current_pc=0, done=0, error=0, retired_count=0 and clear the WAIT counter.
REQ-035 Reset asserted in any state, including mid-WAIT, SHALL take effect at the next edge and discard any in-flight instruction.

Structure
REQ-036 The core-state encodings SHALL reside in a shared package, imported by this block and by the register, ALU, LSU and PC modules.
REQ-037 The block SHALL be a single module with no sub-module; the WAIT completion reduction and watchdog SHALL stay inline.

Verification
REQ-038 Reset, then start=1 with fetch_done=1 and no mem op -> core_state sequence 1,2,3,4,5,6,7,1; WAIT lasts 1 cycle; retired_count=1.
REQ-039 LDR with thread_enable=4'b0111 and lsu_done rising 0001, 0011, 0111 on successive cycles -> EXECUTE entered the cycle after lsu_done=0111; lane 3 is ignored.
REQ-040 RET in UPDATE -> state 8, done=1, current_pc unchanged; start pulses afterwards -> no state change.
REQ-041 STR with MAX_WAIT=4 and lsu_done held 0 -> DONE with error=1 after 4 WAIT cycles.
REQ-042 Reset asserted mid-WAIT with current_pc=8'h2A -> next cycle IDLE, current_pc=0, retired_count=0.
REQ-043 next_pc=8'hFF then 8'h00 across two UPDATEs -> current_pc follows exactly; retired_count preset near 16'hFFFF saturates at 16'hFFFF.
